// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle sequencing controller: opcode map,
// ALU/PC/writeback select codes, FSM state codes and the instruction-class enum.
package ctrl_pkg;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_HALT = 7'b1111111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_MUL = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_ALU   = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_HALTED = 3'd6;
    localparam logic [2:0] ST_ERROR  = 3'd7;

    // Branches are split by condition so EXEC needs only the class and alu_zero.
    typedef enum logic [4:0] {
        CL_NONE    = 5'd0,
        CL_ADD     = 5'd1,
        CL_SUB     = 5'd2,
        CL_MUL     = 5'd3,
        CL_AND     = 5'd4,
        CL_OR      = 5'd5,
        CL_SLL     = 5'd6,
        CL_ADDI    = 5'd7,
        CL_SLLI    = 5'd8,
        CL_LW      = 5'd9,
        CL_SW      = 5'd10,
        CL_BEQ     = 5'd11,
        CL_BNE     = 5'd12,
        CL_BNT     = 5'd13,
        CL_JAL     = 5'd14,
        CL_JALR    = 5'd15,
        CL_HALT    = 5'd16,
        CL_ILLEGAL = 5'd17
    } instr_class_t;

    function automatic logic [2:0] class_alu_op(input instr_class_t cls);
        case (cls)
            CL_SUB, CL_BEQ, CL_BNE, CL_BNT: class_alu_op = ALU_SUB;
            CL_MUL:                         class_alu_op = ALU_MUL;
            CL_AND:                         class_alu_op = ALU_AND;
            CL_OR:                          class_alu_op = ALU_OR;
            CL_SLL, CL_SLLI:                class_alu_op = ALU_SLL;
            default:                        class_alu_op = ALU_ADD;
        endcase
    endfunction

    function automatic logic class_alu_src(input instr_class_t cls);
        case (cls)
            CL_ADDI, CL_SLLI, CL_LW, CL_SW, CL_JALR: class_alu_src = 1'b1;
            default:                                 class_alu_src = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Memory-port and multiplier handshake between the controller and the datapath.
interface multicycle_ctrl_if;
    import ctrl_pkg::*;

    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic mem_ready;
    logic mul_start;
    logic mul_done;

    modport master (output mem_req, mem_we, addr_sel, mul_start,
                    input  mem_ready, mul_done);
    modport slave  (input  mem_req, mem_we, addr_sel, mul_start,
                    output mem_ready, mul_done);
endinterface

// File: rtl/multicycle_ctrl_instr_class_dec.sv
// Pure combinational opcode/func decode into instruction class and ALU op;
// shared between the single-cycle and multi-cycle builds.
module instr_class_dec
    import ctrl_pkg::*;
(
    input  logic [6:0]   opcode,
    input  logic [2:0]   func3,
    input  logic [6:0]   func7,
    output instr_class_t instr_class,
    output logic [2:0]   alu_op
);

    // Classify the instruction word; anything outside the subset is illegal.
    always_comb begin
        instr_class = CL_ILLEGAL;
        case (opcode)
            OP_R: begin
                case (func3)
                    3'b000: begin
                        case (func7)
                            7'b0000000: instr_class = CL_ADD;
                            7'b0100000: instr_class = CL_SUB;
                            7'b0000001: instr_class = CL_MUL;
                            default:    instr_class = CL_ILLEGAL;
                        endcase
                    end
                    3'b111:  instr_class = CL_AND;
                    3'b110:  instr_class = CL_OR;
                    3'b001:  instr_class = CL_SLL;
                    default: instr_class = CL_ILLEGAL;
                endcase
            end
            OP_I: begin
                case (func3)
                    3'b000:  instr_class = CL_ADDI;
                    3'b001:  instr_class = CL_SLLI;
                    default: instr_class = CL_ILLEGAL;
                endcase
            end
            OP_B: begin
                case (func3)
                    3'b000:  instr_class = CL_BEQ;
                    3'b001:  instr_class = CL_BNE;
                    default: instr_class = CL_BNT;
                endcase
            end
            OP_LW:   instr_class = CL_LW;
            OP_SW:   instr_class = CL_SW;
            OP_JAL:  instr_class = CL_JAL;
            OP_JALR: instr_class = CL_JALR;
            OP_HALT: instr_class = CL_HALT;
            default: instr_class = CL_ILLEGAL;
        endcase
    end

    assign alu_op = class_alu_op(instr_class);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencing controller: FETCH/DECODE/EXEC/MEM/WB over a single
// shared memory port, with memory timeout and a retired-instruction counter.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master mem_bus,
    input  logic [6:0]        opcode,
    input  logic [2:0]        func3,
    input  logic [6:0]        func7,
    input  logic              alu_zero,
    output logic              ir_we,
    output logic              pc_we,
    output logic [1:0]        pc_sel,
    output logic              alu_src,
    output logic [2:0]        alu_op,
    output logic              reg_we,
    output logic [1:0]        wb_sel,
    output logic              halted,
    output logic              err,
    output logic [CNT_W-1:0]  instret
);

    localparam int                WAIT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
    localparam bit                TIMEOUT_EN = (TIMEOUT != 0);

    logic [2:0]        state_r, state_nxt;
    instr_class_t      class_r, dec_class;
    logic [2:0]        alu_op_r, dec_alu_op;
    logic [WAIT_W-1:0] wait_r;
    logic              mul_busy_r;
    logic [CNT_W-1:0]  instret_r;
    logic              mem_ready_s, mul_done_s, taken_s, retire_s;
    logic              mem_wait_s, timeout_s, wait_clr_s, wait_inc_s;
    logic              mem_req_s, mem_we_s, addr_sel_s, mul_start_s;

    instr_class_dec u_dec (
        .opcode      (opcode),
        .func3       (func3),
        .func7       (func7),
        .instr_class (dec_class),
        .alu_op      (dec_alu_op)
    );

    assign mem_ready_s = mem_bus.mem_ready;
    assign mul_done_s  = mem_bus.mul_done;
    assign mem_wait_s  = (state_r == ST_FETCH) || (state_r == ST_MEM);
    assign timeout_s   = TIMEOUT_EN && (wait_r == WAIT_LIMIT) && !mem_ready_s;
    assign wait_inc_s  = TIMEOUT_EN && mem_wait_s && !mem_ready_s;
    assign wait_clr_s  = (state_nxt != state_r) &&
                         ((state_nxt == ST_FETCH) || (state_nxt == ST_MEM));
    assign taken_s     = ((class_r == CL_BEQ) && alu_zero) ||
                         ((class_r == CL_BNE) && !alu_zero);

    // Next-state selection and retire strobe.
    always_comb begin
        state_nxt = state_r;
        retire_s  = 1'b0;
        case (state_r)
            ST_IDLE:   state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready_s)    state_nxt = ST_DECODE;
                else if (timeout_s) state_nxt = ST_ERROR;
                else                state_nxt = ST_FETCH;
            end
            ST_DECODE: begin
                if (dec_class == CL_ILLEGAL) state_nxt = ST_ERROR;
                else                         state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                case (class_r)
                    CL_MUL: begin
                        if (mul_done_s) state_nxt = ST_WB;
                        else            state_nxt = ST_EXEC;
                    end
                    CL_LW, CL_SW:           state_nxt = ST_MEM;
                    CL_BEQ, CL_BNE, CL_BNT: begin
                        state_nxt = ST_FETCH;
                        retire_s  = 1'b1;
                    end
                    CL_HALT: begin
                        state_nxt = ST_HALTED;
                        retire_s  = 1'b1;
                    end
                    default:                state_nxt = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (mem_ready_s && (class_r == CL_SW)) begin
                    state_nxt = ST_FETCH;
                    retire_s  = 1'b1;
                end else if (mem_ready_s) begin
                    state_nxt = ST_WB;
                end else if (timeout_s) begin
                    state_nxt = ST_ERROR;
                end else begin
                    state_nxt = ST_MEM;
                end
            end
            ST_WB: begin
                state_nxt = ST_FETCH;
                retire_s  = 1'b1;
            end
            ST_HALTED: state_nxt = ST_HALTED;
            default:   state_nxt = ST_ERROR;
        endcase
    end

    // Control strobes decoded from state, latched class and alu_zero.
    always_comb begin
        mem_req_s   = 1'b0;
        mem_we_s    = 1'b0;
        addr_sel_s  = 1'b0;
        mul_start_s = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_sel      = PC_PLUS4;
        alu_src     = 1'b0;
        alu_op      = ALU_ADD;
        reg_we      = 1'b0;
        wb_sel      = WB_ALU;
        halted      = 1'b0;
        err         = 1'b0;
        case (state_r)
            ST_FETCH: begin
                mem_req_s = 1'b1;
                ir_we     = mem_ready_s;
            end
            ST_EXEC: begin
                alu_op  = alu_op_r;
                alu_src = class_alu_src(class_r);
                case (class_r)
                    CL_MUL:                 mul_start_s = !mul_busy_r;
                    CL_BEQ, CL_BNE, CL_BNT: begin
                        pc_we  = 1'b1;
                        pc_sel = taken_s ? PC_IMM : PC_PLUS4;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                mem_req_s  = 1'b1;
                addr_sel_s = 1'b1;
                mem_we_s   = (class_r == CL_SW);
                pc_we      = (class_r == CL_SW) && mem_ready_s;
            end
            ST_WB: begin
                reg_we = 1'b1;
                pc_we  = 1'b1;
                case (class_r)
                    CL_LW:   wb_sel = WB_MEM;
                    CL_JAL: begin
                        wb_sel = WB_PC4;
                        pc_sel = PC_IMM;
                    end
                    CL_JALR: begin
                        wb_sel  = WB_PC4;
                        pc_sel  = PC_ALU;
                        alu_src = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_HALTED: halted = 1'b1;
            ST_ERROR:  err    = 1'b1;
            default: ;
        endcase
    end

    assign mem_bus.mem_req   = mem_req_s;
    assign mem_bus.mem_we    = mem_we_s;
    assign mem_bus.addr_sel  = addr_sel_s;
    assign mem_bus.mul_start = mul_start_s;
    assign instret           = instret_r;

    // FSM state, decode latch, memory wait counter, multiplier phase and instret.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            class_r    <= CL_NONE;
            alu_op_r   <= ALU_ADD;
            wait_r     <= '0;
            mul_busy_r <= 1'b0;
            instret_r  <= '0;
        end else begin
            state_r <= state_nxt;
            if (state_r == ST_DECODE) begin
                class_r  <= dec_class;
                alu_op_r <= dec_alu_op;
            end
            if (wait_clr_s)      wait_r <= '0;
            else if (wait_inc_s) wait_r <= wait_r + WAIT_ONE;
            // Marks every EXEC cycle after the first, so mul_start pulses once.
            mul_busy_r <= (state_r == ST_EXEC) && (state_nxt == ST_EXEC);
            if (retire_s) instret_r <= instret_r + CNT_W'(1);
        end
    end

endmodule
